// File: rtl/cr16_controller.sv
// cr16_controller: multi-cycle fetch/decode/execute controller for the CR16 datapath.
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   enable_i                           0 freezes all state and masks writes/requests
//   mem_rdata_i, mem_ready_i           memory read data and request completion
//   status_flags_i, reg_b_data_i       datapath ALU flags and O_B (load/store address)
//   mem_req_o, mem_we_o, mem_addr_o    memory request, store strobe, address
//   reg_write_enable_o                 one-hot regfile write enable
//   reg_a_select_o, reg_b_select_o     Rdest / Rsrc fields
//   immediate_o, immediate_select_o    sign-extended imm8 and A-input mux select
//   opcode_o, regfile_data_select_o    ALU opcode and regfile input mux (load)
//   flags_o, pc_o, halted_o            latched flags, program counter, halt status
module cr16_controller #(
    parameter int                    P_PC_WIDTH = 16,
    parameter logic [P_PC_WIDTH-1:0] P_RESET_PC = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic [15:0]           mem_rdata_i,
    input  logic                  mem_ready_i,
    input  logic [4:0]            status_flags_i,
    input  logic [15:0]           reg_b_data_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [P_PC_WIDTH-1:0] mem_addr_o,
    output logic [15:0]           reg_write_enable_o,
    output logic [3:0]            reg_a_select_o,
    output logic [3:0]            reg_b_select_o,
    output logic [15:0]           immediate_o,
    output logic                  immediate_select_o,
    output logic [3:0]            opcode_o,
    output logic                  regfile_data_select_o,
    output logic [4:0]            flags_o,
    output logic [P_PC_WIDTH-1:0] pc_o,
    output logic                  halted_o
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;

    state_t                state_q, state_d;
    logic [P_PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]           ir_q, ir_d;
    logic [4:0]            flags_q, flags_d;

    logic [3:0] op, ext, rdest;
    logic       is_rtype, is_itype, is_cmp, is_load, is_store;

    assign op       = ir_q[15:12];
    assign rdest    = ir_q[11:8];
    assign ext      = ir_q[7:4];
    assign is_rtype = op == 4'h0;
    assign is_itype = op >= 4'h1 && op <= 4'hB && op != 4'h4;
    assign is_cmp   = is_rtype && ext == 4'hB;
    assign is_load  = op == 4'h4 && ext == 4'h0;
    assign is_store = op == 4'h4 && ext == 4'h4;

    assign reg_a_select_o     = rdest;
    assign reg_b_select_o     = ir_q[3:0];
    assign immediate_o        = {{8{ir_q[7]}}, ir_q[7:0]};
    assign immediate_select_o = is_itype;
    assign opcode_o           = is_rtype ? ext : op;
    assign mem_addr_o         = state_q == S_MEM ? P_PC_WIDTH'(reg_b_data_i) : pc_q;
    assign flags_o            = flags_q;
    assign pc_o               = pc_q;
    assign halted_o           = state_q == S_HALT;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_FETCH;
            pc_q    <= P_RESET_PC;
            ir_q    <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
        end
    end

    // rst_ni gates the strobes so an asserted reset kills a request at once,
    // even though the reset state itself is S_FETCH.
    always_comb begin
        state_d               = state_q;
        pc_d                  = pc_q;
        ir_d                  = ir_q;
        flags_d               = flags_q;
        mem_req_o             = 1'b0;
        mem_we_o              = 1'b0;
        reg_write_enable_o    = '0;
        regfile_data_select_o = 1'b0;
        if (enable_i && rst_ni) begin
            case (state_q)
                S_FETCH: begin
                    mem_req_o = 1'b1;
                    if (mem_ready_i) begin
                        ir_d    = mem_rdata_i;
                        pc_d    = pc_q + P_PC_WIDTH'(1);
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: state_d = (is_rtype || is_itype) ? S_EXEC
                                  : (is_load || is_store)  ? S_MEM : S_HALT;
                S_EXEC: begin
                    reg_write_enable_o = is_cmp ? 16'h0000 : 16'h0001 << rdest;
                    flags_d            = status_flags_i;
                    state_d            = S_FETCH;
                end
                S_MEM: begin
                    mem_req_o = 1'b1;
                    mem_we_o  = is_store;
                    if (mem_ready_i) begin
                        regfile_data_select_o = is_load;
                        reg_write_enable_o    = is_load ? 16'h0001 << rdest : 16'h0000;
                        state_d               = S_FETCH;
                    end
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_FETCH;
            endcase
        end
    end
endmodule

// File: doc/cr16_controller.md
Name: cr16_controller

Overview:
- Multi-cycle fetch/decode/execute controller that drives every control input of the CR16 datapath: register selects, one-hot write enable, immediate, ALU opcode and mux selects.
- Owns the program counter and the instruction register.
- Runs the memory request/ready handshake for instruction fetch, load and store.
- Latches the ALU status flags returned by the datapath.

Parameters:
- P_PC_WIDTH, 16, width of program counter and memory address.
- P_RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- I_CLK  input  1  clock, all state updates on rising edge.
- I_NRESET  input  1  asynchronous active-low reset.
- I_ENABLE  input  1  when 0, all state holds and no register write or memory request is asserted.
- I_MEM_RDATA  input  16  memory read data (instruction or load data), valid when I_MEM_READY=1.
- I_MEM_READY  input  1  memory completes current request this cycle.
- I_STATUS_FLAGS  input  5  datapath ALU status flags.
- I_REG_B_DATA  input  16  datapath O_B value, used as load/store address.
- O_MEM_REQ  output  1  memory request.
- O_MEM_WE  output  1  store request (valid with O_MEM_REQ).
- O_MEM_ADDR  output  P_PC_WIDTH  memory address.
- O_REG_WRITE_ENABLE  output  16  one-hot datapath regfile write enable.
- O_REG_A_SELECT  output  4  Rdest field, instr[11:8].
- O_REG_B_SELECT  output  4  Rsrc field, instr[3:0].
- O_IMMEDIATE  output  16  sign-extended instr[7:0].
- O_IMMEDIATE_SELECT  output  1  datapath A input = immediate.
- O_OPCODE  output  4  ALU opcode.
- O_REGFILE_DATA_SELECT  output  1  regfile input = I_MEM_RDATA (load).
- O_FLAGS  output  5  latched status flags.
- O_PC  output  P_PC_WIDTH  current PC.
- O_HALTED  output  1  controller is in S_HALT.

Behaviour:
- Reset (async, I_NRESET=0):
  - state=S_FETCH, PC=P_RESET_PC, IR=0, O_FLAGS=0, O_HALTED=0.
  - All write-enable, request and select outputs=0.
  - Reset mid-handshake aborts the request immediately; no register write occurs.
- Instruction format: op=instr[15:12], Rdest=[11:8], ext=[7:4], Rsrc=[3:0], imm8=[7:0].
  - R-type: op=0000; ALU opcode=ext. CMP is ext=1011.
  - I-type: op in 0001..1011 except 0100; ALU opcode=op; A input=sign-extended imm8.
  - Memory: op=0100. ext=0000 is LOAD (Rdest <= mem[Rsrc]); ext=0100 is STORE (mem[Rsrc] <= Rdest).
  - All other encodings are illegal.
- S_FETCH:
  - O_MEM_REQ=1, O_MEM_WE=0, O_MEM_ADDR=PC.
  - Holds until I_MEM_READY=1; then IR<=I_MEM_RDATA, PC<=PC+1 (wraps 16'hFFFF to 0), next state S_DECODE.
- S_DECODE (1 cycle, no side effects):
  - ALU op -> S_EXEC.
  - LOAD/STORE -> S_MEM.
  - Illegal -> S_HALT.
- S_EXEC (1 cycle):
  - O_REG_WRITE_ENABLE = 1<<Rdest; zero for CMP.
  - O_IMMEDIATE_SELECT=1 for I-type.
  - O_FLAGS <= I_STATUS_FLAGS.
  - Next state S_FETCH.
- S_MEM:
  - O_MEM_REQ=1, O_MEM_ADDR=I_REG_B_DATA; O_MEM_WE=1 for STORE.
  - Holds until I_MEM_READY.
  - On the ready cycle, LOAD asserts O_REGFILE_DATA_SELECT=1 and O_REG_WRITE_ENABLE = 1<<Rdest, for that single cycle only.
  - Flags are not updated. Next state S_FETCH.
- S_HALT: terminal. All enables and requests 0, O_HALTED=1; exits only via reset.
- Decoded outputs:
  - Select, immediate and opcode outputs are combinational from IR in every state.
  - Write enables and requests are asserted only in the states listed above.
- Timing: ALU instruction takes 3 cycles with zero-wait memory; load/store takes 3 cycles + memory waits on each access.
- I_ENABLE=0 in any state:
  - State, PC, IR and flags freeze.
  - O_MEM_REQ=0 and O_REG_WRITE_ENABLE=0.
  - I_MEM_READY is ignored that cycle; memory must re-complete after enable returns.
- I_MEM_READY outside S_FETCH/S_MEM is ignored.

Test Plan:
- Reset then zero-wait fetch of 16'h0153 (R-type ADD-ext 5, Rdest=1, Rsrc=3) -> O_MEM_ADDR=0 in cycle 1. In cycle 3, O_REG_WRITE_ENABLE=16'h0002 and O_OPCODE=4'h5; PC=1; back to fetch.
- I-type 16'h52F0 -> O_IMMEDIATE=16'hFFF0, O_IMMEDIATE_SELECT=1, O_OPCODE=4'h5, write enable 16'h0004. I_STATUS_FLAGS=5'b10101 latched to O_FLAGS.
- LOAD 16'h4702 with I_REG_B_DATA=16'h0040, memory ready after 2 waits with data 16'hBEEF -> O_MEM_ADDR=16'h0040 for 3 cycles. Final cycle: O_REGFILE_DATA_SELECT=1, write enable 16'h0080.
- STORE 16'h4443 -> O_MEM_WE=1 while requesting; no write enable asserted; O_FLAGS unchanged.
- CMP (ext=1011) -> write enable stays 0 throughout, flags update. Illegal 16'hF000 -> O_HALTED=1 and no further O_MEM_REQ until reset.
- I_ENABLE=0 during a fetch wait with I_MEM_READY=1 -> no IR or PC update. PC=16'hFFFF fetch -> PC wraps to 0. I_NRESET pulse in S_MEM -> O_MEM_REQ drops asynchronously, PC=0.
